// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulus counter family.
// Mode and direction encodings used by the counter and its users.
package counter_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one tick per DIV enabled cycles.
// With DIV=1 it collapses to a wire (tick = en) and holds no state.
module counter_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  if (DIV < 1) begin : g_bad_div
    $error("counter_prescaler: DIV must be >= 1 (got %0d)", DIV);
  end

  if (DIV <= 1) begin : g_pass
    logic unused_pass;
    assign unused_pass = &{1'b0, clk, reset_n, sync_clr};
    assign tick = en;
  end else begin : g_div
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q;

    // Holds while en is low so a paused run resumes mid-prescale.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
      end else if (sync_clr) begin
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
      end
    end

    assign tick = en && (cnt_q == LAST);
  end

endmodule

// File: rtl/mod_counter_updown.sv
// Up/down modulus counter over 0..MAX_VAL with prescaled enable,
// sync clear, clamped parallel load and wrap or one-shot (halt) mode.
module mod_counter_updown
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH - 1,
  parameter int DIV     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             halted
);

  if (WIDTH < 2) begin : g_bad_width
    $error("mod_counter_updown: WIDTH must be >= 2 (got %0d)", WIDTH);
  end
  if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("mod_counter_updown: MAX_VAL %0d out of range for WIDTH %0d", MAX_VAL, WIDTH);
  end
  if (DIV < 1) begin : g_bad_div
    $error("mod_counter_updown: DIV must be >= 1 (got %0d)", DIV);
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  logic             tick;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             halted_q, halted_d;

  counter_prescaler #(.DIV(DIV)) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .sync_clr (clr | load),
    .tick     (tick)
  );

  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    halted_d = halted_q;
    if (clr) begin
      count_d  = '0;
      halted_d = 1'b0;
    end else if (load) begin
      count_d  = (load_val > MAX_C) ? MAX_C : load_val;
      halted_d = 1'b0;
    end else if (tick && !halted_q) begin
      // At the terminal value: wrap in wrap mode, otherwise freeze and flag.
      if (dir == DIR_UP) begin
        if (count_q < MAX_C) begin
          count_d = count_q + WIDTH'(1);
        end else if (mode == MODE_ONESHOT) begin
          halted_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else if (mode == MODE_ONESHOT) begin
          halted_d = 1'b1;
        end else begin
          count_d = MAX_C;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      wrap_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_q   <= wrap_d;
      halted_q <= halted_d;
    end
  end

  assign count  = count_q;
  assign wrap   = wrap_q;
  assign halted = halted_q;
  assign tc     = (dir == DIR_UP) ? (count_q == MAX_C) : (count_q == '0);

endmodule

// File: tb/tb_mod_counter_updown.sv
// Bench for mod_counter_updown: a DIV=1 and a DIV=3 instance share stimulus;
// a reference model feeds per-instance expected queues drained by a monitor.
module tb_mod_counter_updown;

  localparam int W    = 4;
  localparam int MAXV = 9;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b1, mode = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] count_a, count_b;
  logic         tc_a, wrap_a, halted_a, tc_b, wrap_b, halted_b;

  int n_checks = 0;
  int n_pass   = 0;

  // expected {count, tc, wrap, halted}
  logic [W+2:0] exp_a_q[$];
  logic [W+2:0] exp_b_q[$];

  int a_cnt = 0, a_pre = 0, b_cnt = 0, b_pre = 0;
  bit a_hal = 0, a_wr = 0, b_hal = 0, b_wr = 0;

  always #5 clk = ~clk;

  mod_counter_updown #(.WIDTH(W), .MAX_VAL(MAXV), .DIV(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .mode(mode),
    .count(count_a), .tc(tc_a), .wrap(wrap_a), .halted(halted_a)
  );

  mod_counter_updown #(.WIDTH(W), .MAX_VAL(MAXV), .DIV(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .mode(mode),
    .count(count_b), .tc(tc_b), .wrap(wrap_b), .halted(halted_b)
  );

  function automatic logic [W+2:0] pack(input int cnt, input logic d, input logic w, input logic h);
    logic [W-1:0] c;
    logic         t;
    c = W'(cnt);
    t = d ? (cnt == MAXV) : (cnt == 0);
    return {c, t, w, h};
  endfunction

  // Behavioural model of one clock edge for a counter with prescale div.
  task automatic model_edge(input int div, inout int cnt, inout int pre, inout bit hal, output bit wr);
    bit tick;
    wr   = 0;
    tick = 0;
    if (clr) begin
      cnt = 0; pre = 0; hal = 0;
    end else if (load) begin
      cnt = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      pre = 0; hal = 0;
    end else begin
      if (en) begin
        pre = pre + 1;
        if (pre == div) begin
          pre  = 0;
          tick = 1;
        end
      end
      if (tick && !hal) begin
        if (dir) begin
          if (cnt < MAXV) cnt = cnt + 1;
          else if (mode) hal = 1;
          else begin cnt = 0; wr = 1; end
        end else begin
          if (cnt > 0) cnt = cnt - 1;
          else if (mode) hal = 1;
          else begin cnt = MAXV; wr = 1; end
        end
      end
    end
  endtask

  task automatic push_expected();
    exp_a_q.push_back(pack(a_cnt, dir, a_wr, a_hal));
    exp_b_q.push_back(pack(b_cnt, dir, b_wr, b_hal));
  endtask

  task automatic step(input logic e, input logic c, input logic l,
                      input logic d, input logic m, input logic [W-1:0] lv);
    @(negedge clk);
    en = e; clr = c; load = l; dir = d; mode = m; load_val = lv;
    @(posedge clk);
    model_edge(1, a_cnt, a_pre, a_hal, a_wr);
    model_edge(3, b_cnt, b_pre, b_hal, b_wr);
    push_expected();
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    a_cnt = 0; a_pre = 0; a_hal = 0; a_wr = 0;
    b_cnt = 0; b_pre = 0; b_hal = 0; b_wr = 0;
  endtask

  // Assert reset between edges, check it took effect without a clock edge.
  task automatic reset_mid();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_count_a", int'(count_a), 0);
    check("async_rst_wrap_a", int'(wrap_a), 0);
    check("async_rst_halted_a", int'(halted_a), 0);
    check("async_rst_count_b", int'(count_b), 0);
    model_reset();
    en = 1'b0; clr = 1'b0; load = 1'b0;
    repeat (2) begin
      @(posedge clk);
      push_expected();
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  always @(posedge clk) begin
    logic [W+2:0] e;
    #1;
    if (exp_a_q.size() != 0) begin
      e = exp_a_q.pop_front();
      n_checks++;
      if ({count_a, tc_a, wrap_a, halted_a} === e) n_pass++;
      else $display("FAIL dut_a t=%0t: {count,tc,wrap,halted} got %b_%b%b%b, expected %b_%b%b%b",
                    $time, count_a, tc_a, wrap_a, halted_a, e[W+2:3], e[2], e[1], e[0]);
    end
    if (exp_b_q.size() != 0) begin
      e = exp_b_q.pop_front();
      n_checks++;
      if ({count_b, tc_b, wrap_b, halted_b} === e) n_pass++;
      else $display("FAIL dut_b t=%0t: {count,tc,wrap,halted} got %b_%b%b%b, expected %b_%b%b%b",
                    $time, count_b, tc_b, wrap_b, halted_b, e[W+2:3], e[2], e[1], e[0]);
    end
  end

  initial begin
    int r;
    logic ce, cc, cl, cd, cm;
    #1;
    check("reset_count_a", int'(count_a), 0);
    check("reset_wrap_a", int'(wrap_a), 0);
    check("reset_halted_a", int'(halted_a), 0);
    check("reset_tc_up_a", int'(tc_a), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Up count, wrap mode: 1..9 then wrap to 0 with a wrap pulse.
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 1, 0, 0);
      if (i == 8) begin #1 check("up_tc_at_9", int'(tc_a), 1); end
      if (i == 9) begin #1 check("up_wrap_to_0", int'({count_a, wrap_a}), 1); end
    end

    // Clear, then count down with wrap to MAX_VAL.
    step(0, 1, 0, 0, 0, 0);
    #1 check("clr_down_tc", int'(tc_a), 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (i == 0) begin #1 check("down_wrap_to_9", int'({count_a, wrap_a}), 19); end
    end

    // One-shot up from 7: halts at 9 without a wrap pulse.
    step(0, 0, 1, 1, 1, 7);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 1, 0);
    #1 check("oneshot_halted", int'({count_a, halted_a, wrap_a}), 9 * 4 + 2);
    step(0, 1, 0, 1, 1, 0);
    #1 check("clr_clears_halt", int'({count_a, halted_a}), 0);

    // Load clamp, clr beats load, load clears halted.
    step(0, 0, 1, 1, 0, 15);
    #1 check("load_clamp", int'(count_a), 9);
    step(0, 1, 1, 1, 0, 5);
    #1 check("clr_over_load", int'(count_a), 0);
    step(1, 0, 0, 0, 1, 0);
    #1 check("halt_at_0_down", int'(halted_a), 1);
    step(0, 0, 1, 0, 1, 3);
    #1 check("load_clears_halt", int'({count_a, halted_a}), 6);

    // DIV=3 instance: 9 enabled cycles give 3 steps, then pause mid-prescale.
    step(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0, 0);
    #1 check("div3_nine_cycles", int'(count_b), 3);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    #1 check("div3_paused_no_step", int'(count_b), 3);
    step(1, 0, 0, 1, 0, 0);
    #1 check("div3_delayed_step", int'(count_b), 4);

    // Run to 6 then reset between edges.
    step(0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0, 0);
    #1 check("pre_reset_count_6", int'(count_a), 6);
    reset_mid();
    step(1, 0, 0, 1, 0, 0);
    #1 check("resume_after_reset", int'(count_a), 1);

    // Randomized mix of all controls.
    cd = 1'b1; cm = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r  = $urandom_range(0, 99);
      cc = (r < 4);
      cl = (r >= 4 && r < 12);
      ce = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) cd = ~cd;
      if ($urandom_range(0, 14) == 0) cm = ~cm;
      step(ce, cc, cl, cd, cm, W'($urandom_range(0, 15)));
    end

    @(negedge clk);
    check("queues_drained", exp_a_q.size() + exp_b_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mod_counter_updown.md
Name: mod_counter_updown

Overview:
Parametrised successor to the team's fixed 4-bit free-running counter. Counts up or down over a configurable modulus 0..MAX_VAL. Has an enable prescaler, synchronous clear, parallel load with clamping, and wrap or one-shot (halt) mode. Used as the general timer/sequencer counter in test designs and peripheral blocks.

Parameters:
WIDTH, 8, bit width of count and load_val; must be >= 2.
MAX_VAL, 2**WIDTH-1, highest count value; range 1 .. 2**WIDTH-1.
DIV, 1, prescale factor; one count step per DIV enabled cycles; must be >= 1.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  reset, asynchronous, active-low
en  input  1  count enable; feeds the prescaler
clr  input  1  synchronous clear
load  input  1  synchronous parallel load
load_val  input  WIDTH  value to load
dir  input  1  1 = count up, 0 = count down
mode  input  1  0 = wrap, 1 = one-shot (halt at terminal value)
count  output  WIDTH  current count, registered
tc  output  1  terminal-count decode, combinational from count and dir
wrap  output  1  one-cycle registered pulse on wrap-around
halted  output  1  sticky flag; one-shot run finished

Behaviour:
- Reset (reset_n low, asynchronous): count=0, wrap=0, halted=0, prescaler=0. Takes effect immediately, with no clock edge needed, including mid-count. Release is synchronous to clk.
- Priority per rising edge: clr > load > tick.
- clr: count=0, halted=0, prescaler=0, wrap=0.
- load: count = min(load_val, MAX_VAL), halted=0, prescaler=0, wrap=0.
- Prescaler: counts cycles with en=1, range 0..DIV-1.
  - tick = en && prescaler==DIV-1.
  - On tick the prescaler goes to 0. When en=0 the prescaler holds.
  - DIV=1: tick = en; no prescaler register is required.
- Tick while halted=1: ignored; count holds and the prescaler keeps running.
- Tick, dir=1:
  - count < MAX_VAL: count+1.
  - count == MAX_VAL, mode=0: count=0, wrap=1 next cycle.
  - count == MAX_VAL, mode=1: count holds, halted=1.
- Tick, dir=0:
  - count > 0: count-1.
  - count == 0, mode=0: count=MAX_VAL, wrap=1.
  - count == 0, mode=1: count holds, halted=1.
- wrap is asserted in the same cycle the new (wrapped) count is visible. Otherwise it is 0.
- tc = (dir && count==MAX_VAL) || (!dir && count==0). It is valid in every cycle, including while halted.
- Changing dir or mode mid-run takes effect on the next tick. Changing mode to 0 does not clear halted; only clr, load or reset clear it.
- No arithmetic overflow beyond MAX_VAL is possible. All compares use WIDTH bits, and the clamp compare is unsigned.
- Parameter violations (MAX_VAL > 2**WIDTH-1, DIV < 1) must raise a simulation-time error at elaboration.

Decomposition:
- Shared package counter_pkg holds:
  - mode constants MODE_WRAP=1'b0 and MODE_ONESHOT=1'b1;
  - direction constants DIR_DOWN=1'b0 and DIR_UP=1'b1.
- One sub-module, counter_prescaler (parameter DIV; ports clk, reset_n, en, sync_clr, tick). It is generated as a pass-through when DIV=1.
- Next-count and wrap/halt logic stay in mod_counter_updown.

Test Plan:
1. WIDTH=4, MAX_VAL=9, DIV=1; reset, then en=1, dir=1, mode=0 for 12 cycles.
   - count must read 0,1,...,9,0,1.
   - tc=1 only while count=9.
   - wrap=1 only in the cycle count returns to 0.
2. Same instance; clr, then dir=0, en=1.
   - count must read 0,9,8,7.
   - wrap=1 with the first 9; tc=1 while count=0.
3. mode=1, dir=1; load load_val=7, then en=1.
   - count must read 7,8,9,9,9; halted=1 from the cycle after the tick at 9, and wrap stays 0.
   - Then clr: count=0, halted=0.
4. load_val=15 with MAX_VAL=9: count=9 after load.
   - load and clr together with load_val=5: count=0.
   - load while halted: halted=0.
5. DIV=3 instance: en=1 for 9 cycles gives count=3.
   - en low for 2 cycles in mid-prescale, then high again: the step is delayed exactly 2 cycles.
6. Count running at 6: drive reset_n low between clock edges.
   - count=0, wrap=0 and halted=0 immediately, with no clock edge.
   - After release, counting resumes from 0 on the first tick.
